// File: rtl/mac_sign_pipe_pkg.sv
// Shared types and helpers for the pipelined signed multiply-accumulate engine.
package mac_pkg;

    // Widest product the multiplier pipeline carries; products are sign-extended into this field.
    localparam int PROD_MAX_W = 64;

    // One multiplier pipeline stage: beat valid, end-of-vector marker and sign-extended product.
    typedef struct packed {
        logic                         valid;
        logic                         last;
        logic signed [PROD_MAX_W-1:0] prod;
    } stage_t;

    // Largest signed value representable in accW bits, sign-extended to PROD_MAX_W.
    function automatic logic signed [PROD_MAX_W-1:0] sat_max(input int accW);
        logic [PROD_MAX_W-1:0] one;
        one = {{(PROD_MAX_W-1){1'b0}}, 1'b1};
        return signed'((one << (accW - 1)) - one);
    endfunction

    // Smallest signed value representable in accW bits, sign-extended to PROD_MAX_W.
    function automatic logic signed [PROD_MAX_W-1:0] sat_min(input int accW);
        logic [PROD_MAX_W-1:0] one;
        one = {{(PROD_MAX_W-1){1'b0}}, 1'b1};
        return signed'(~((one << (accW - 1)) - one));
    endfunction

endpackage

// File: rtl/mac_sign_pipe_if.sv
// Streaming operand input and result output bundle of the MAC engine.
interface mac_sign_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] op1;
    logic signed [DATA_W-1:0] op2;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     out_ovf;

    // Producer/consumer side: supplies operand beats and accepts results.
    modport master (
        output in_valid, op1, op2, in_last, out_ready,
        input  in_ready, out_valid, acc_out, out_ovf
    );

    // Engine side.
    modport slave (
        input  in_valid, op1, op2, in_last, out_ready,
        output in_ready, out_valid, acc_out, out_ovf
    );
endinterface

// File: rtl/mac_sign_pipe_mul.sv
// Signed DATA_W x DATA_W multiplier with MUL_STAGES registered stages and valid/last sidebands.
module mul_sign_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MUL_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic signed [DATA_W-1:0] i_op1,
    input  logic signed [DATA_W-1:0] i_op2,
    output stage_t                   o_stage
);

    if (MUL_STAGES < 1) begin : g_err_stages
        $error("mul_sign_pipe: MUL_STAGES must be at least 1");
    end
    if (2 * DATA_W > PROD_MAX_W) begin : g_err_width
        $error("mul_sign_pipe: product does not fit the stage record");
    end

    logic signed [2*DATA_W-1:0] w_prod;
    stage_t                     r_stage [MUL_STAGES];

    assign w_prod  = i_op1 * i_op2;
    assign o_stage = r_stage[MUL_STAGES-1];

    // Shift the product and its sidebands down the pipeline whenever the engine advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= '{valid: i_valid, last: i_last, prod: PROD_MAX_W'(w_prod)};
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

endmodule

// File: rtl/mac_sign_pipe.sv
// Pipelined signed multiply-accumulate: one dot product with sticky overflow per operand vector.
module mac_sign_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int MUL_STAGES = 2,
    parameter bit SATURATE   = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    mac_sign_pipe_if.slave bus
);

    // One guard bit above the widest operand of the add makes the sum exact.
    localparam int SUM_W = PROD_MAX_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(sat_max(ACC_W));
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(sat_min(ACC_W));

    if (ACC_W < 2 * DATA_W) begin : g_err_acc_narrow
        $error("mac_sign_pipe: ACC_W must be at least 2*DATA_W");
    end
    if (ACC_W > PROD_MAX_W) begin : g_err_acc_wide
        $error("mac_sign_pipe: ACC_W exceeds supported width");
    end

    stage_t                  w_fin;
    logic                    w_en;
    logic signed [SUM_W-1:0] w_sum;
    logic                    w_ovf_now;
    logic signed [ACC_W-1:0] w_next;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sticky;
    logic signed [ACC_W-1:0] r_acc_out;
    logic                    r_out_ovf;
    logic                    r_out_valid;

    // The whole engine stalls only while a result is offered and not taken.
    assign w_en         = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = w_en && rst_n;
    assign bus.out_valid = r_out_valid;
    assign bus.acc_out   = r_acc_out;
    assign bus.out_ovf   = r_out_ovf;

    mul_sign_pipe #(
        .DATA_W    (DATA_W),
        .MUL_STAGES(MUL_STAGES)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en),
        .i_valid(bus.in_valid),
        .i_last (bus.in_last),
        .i_op1  (bus.op1),
        .i_op2  (bus.op2),
        .o_stage(w_fin)
    );

    // Exact sum of accumulator and product, range check, then wrap or clamp into ACC_W bits.
    always_comb begin
        w_sum     = SUM_W'(r_acc) + SUM_W'($signed(w_fin.prod));
        w_ovf_now = (w_sum > SAT_HI) || (w_sum < SAT_LO);
        w_next    = w_sum[ACC_W-1:0];
        if (SATURATE && w_ovf_now) begin
            w_next = w_sum[SUM_W-1] ? SAT_LO[ACC_W-1:0] : SAT_HI[ACC_W-1:0];
        end
    end

    // Accumulate beats; on the last beat publish the result and restart from zero with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_sticky    <= 1'b0;
            r_acc_out   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= 1'b0;
            if (w_fin.valid) begin
                if (w_fin.last) begin
                    r_acc_out   <= w_next;
                    r_out_ovf   <= r_sticky | w_ovf_now;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_sticky    <= 1'b0;
                end else begin
                    r_acc    <= w_next;
                    r_sticky <= r_sticky | w_ovf_now;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_sign_pipe.sv
// Self-checking bench for mac_sign_pipe: three instances cover default, saturating and wrapping builds.
module tb_mac_sign_pipe;

    typedef struct {
        longint val;
        bit     ovf;
        int     cyc;
    } res_t;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            inValid = 1'b0;
    logic            inLast = 1'b0;
    logic            outReady = 1'b1;
    logic signed [7:0] op1 = '0;
    logic signed [7:0] op2 = '0;
    int              sel = 0;

    logic              obsInReady;
    logic              obsOutValid;
    logic              obsOvf;
    logic signed [31:0] obsAcc;

    res_t   expQ[$];
    res_t   gotQ[$];
    int     nVec = 0;
    int     nBad = 0;
    int     cycleCnt = 0;
    int     lastAcceptCyc = 0;
    longint mAcc = 0;
    bit     mSticky = 1'b0;
    int     mAccW = 32;
    bit     mSat = 1'b0;
    int     mStages = 2;
    bit     rndReady = 1'b0;

    always #5 clk = ~clk;

    mac_sign_pipe_if #(.DATA_W(8), .ACC_W(32)) ifA ();
    mac_sign_pipe_if #(.DATA_W(8), .ACC_W(16)) ifB ();
    mac_sign_pipe_if #(.DATA_W(8), .ACC_W(16)) ifC ();

    mac_sign_pipe #(.DATA_W(8), .ACC_W(32), .MUL_STAGES(2), .SATURATE(1'b0))
        dutA (.clk(clk), .rst_n(rstN), .bus(ifA));
    mac_sign_pipe #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(1), .SATURATE(1'b1))
        dutB (.clk(clk), .rst_n(rstN), .bus(ifB));
    mac_sign_pipe #(.DATA_W(8), .ACC_W(16), .MUL_STAGES(4), .SATURATE(1'b0))
        dutC (.clk(clk), .rst_n(rstN), .bus(ifC));

    assign ifA.in_valid  = (sel == 0) ? inValid : 1'b0;
    assign ifB.in_valid  = (sel == 1) ? inValid : 1'b0;
    assign ifC.in_valid  = (sel == 2) ? inValid : 1'b0;
    assign ifA.out_ready = (sel == 0) ? outReady : 1'b1;
    assign ifB.out_ready = (sel == 1) ? outReady : 1'b1;
    assign ifC.out_ready = (sel == 2) ? outReady : 1'b1;
    assign ifA.op1 = op1;
    assign ifB.op1 = op1;
    assign ifC.op1 = op1;
    assign ifA.op2 = op2;
    assign ifB.op2 = op2;
    assign ifC.op2 = op2;
    assign ifA.in_last = inLast;
    assign ifB.in_last = inLast;
    assign ifC.in_last = inLast;

    // Route the selected instance's outputs to the observation signals.
    always_comb begin
        obsInReady  = ifA.in_ready;
        obsOutValid = ifA.out_valid;
        obsOvf      = ifA.out_ovf;
        obsAcc      = ifA.acc_out;
        if (sel == 1) begin
            obsInReady  = ifB.in_ready;
            obsOutValid = ifB.out_valid;
            obsOvf      = ifB.out_ovf;
            obsAcc      = 32'(ifB.acc_out);
        end else if (sel == 2) begin
            obsInReady  = ifC.in_ready;
            obsOutValid = ifC.out_valid;
            obsOvf      = ifC.out_ovf;
            obsAcc      = 32'(ifC.acc_out);
        end
    end

    function automatic longint wrapTo(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // Choose which instance is driven and load its build options into the golden model.
    task automatic set_target(input int s);
        sel = s;
        mAccW   = (s == 0) ? 32 : 16;
        mSat    = (s == 1);
        mStages = (s == 0) ? 2 : ((s == 1) ? 1 : 4);
        mAcc    = 0;
        mSticky = 1'b0;
    endtask

    // Golden behavioural model of one accepted beat; completed vectors go to the scoreboard.
    task automatic model_beat(input longint a, input longint b, input bit last);
        longint one, p, sum, mx, mn, nv;
        bit     o;
        one = 1;
        p   = a * b;
        sum = mAcc + p;
        mx  = (one <<< (mAccW - 1)) - 1;
        mn  = -(one <<< (mAccW - 1));
        o   = (sum > mx) || (sum < mn);
        nv  = sum;
        if (o) nv = mSat ? ((sum > mx) ? mx : mn) : wrapTo(sum, mAccW);
        if (last) begin
            expQ.push_back('{nv, mSticky | o, 0});
            mAcc    = 0;
            mSticky = 1'b0;
        end else begin
            mAcc    = nv;
            mSticky = mSticky | o;
        end
    endtask

    // One clock: sample handshakes just before the edge, then return at the falling edge.
    task automatic step(output bit accepted);
        #1;
        accepted = rstN && inValid && (obsInReady === 1'b1);
        if (accepted) begin
            model_beat(longint'(op1), longint'(op2), inLast);
            lastAcceptCyc = cycleCnt;
        end
        if (rstN && obsOutValid === 1'b1 && outReady) begin
            gotQ.push_back('{longint'(obsAcc), obsOvf, cycleCnt});
        end
        @(posedge clk);
        cycleCnt++;
        @(negedge clk);
    endtask

    task automatic send(input logic signed [7:0] a, input logic signed [7:0] b, input bit last);
        bit acc;
        int budget;
        op1 = a;
        op2 = b;
        inLast = last;
        inValid = 1'b1;
        budget = 0;
        acc = 1'b0;
        while (!acc && budget < 200) begin
            if (rndReady) outReady = ($urandom % 4) != 0;
            step(acc);
            budget++;
        end
        inValid = 1'b0;
        if (!acc) begin
            nVec++;
            nBad++;
            $display("[TB] FAIL send_timeout beat not accepted within %0d cycles", budget);
        end
    endtask

    task automatic drain(output bit ok);
        bit a;
        int budget;
        inValid = 1'b0;
        outReady = 1'b1;
        budget = 0;
        while (gotQ.size() < expQ.size() && budget < 300) begin
            step(a);
            budget++;
        end
        for (int i = 0; i < 10; i++) step(a);
        ok = (gotQ.size() == expQ.size());
    endtask

    task automatic do_reset();
        bit a;
        rstN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        step(a);
        rstN = 1'b1;
        mAcc = 0;
        mSticky = 1'b0;
        expQ.delete();
        gotQ.delete();
    endtask

    task automatic test_reset();
        bit a;
        set_target(0);
        rstN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b1;
        #1;
        nVec++;
        if (obsInReady !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL reset_in_ready_low got %b want 0", obsInReady);
        end
        step(a);
        rstN = 1'b1;
        #1;
        nVec++;
        if (obsInReady !== 1'b1 || obsOutValid !== 1'b0 || obsAcc !== 32'sd0 || obsOvf !== 1'b0) begin
            nBad++;
            $display("[TB] FAIL reset_state got rdy=%b vld=%b acc=%0d ovf=%b want 1 0 0 0",
                     obsInReady, obsOutValid, obsAcc, obsOvf);
        end
        expQ.delete();
        gotQ.delete();
    endtask

    task automatic test_single_beat();
        bit ok;
        set_target(0);
        send(-8'sd128, -8'sd128, 1'b1);
        drain(ok);
        nVec++;
        if (gotQ.size() != 1) begin
            nBad++;
            $display("[TB] FAIL single_count got %0d want 1", gotQ.size());
        end else begin
            nVec++;
            if (gotQ[0].val != 16384 || gotQ[0].ovf != 1'b0) begin
                nBad++;
                $display("[TB] FAIL single_value got %0d/%0b want 16384/0", gotQ[0].val, gotQ[0].ovf);
            end
            nVec++;
            if (gotQ[0].cyc - lastAcceptCyc != 3) begin
                nBad++;
                $display("[TB] FAIL single_latency got %0d want 3", gotQ[0].cyc - lastAcceptCyc);
            end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    task automatic test_vector();
        bit ok;
        set_target(0);
        send(8'sd3, 8'sd4, 1'b0);
        send(-8'sd5, 8'sd6, 1'b0);
        send(8'sd127, 8'sd127, 1'b0);
        send(-8'sd1, -8'sd128, 1'b1);
        drain(ok);
        nVec++;
        if (gotQ.size() != 1) begin
            nBad++;
            $display("[TB] FAIL vector_pulses got %0d want 1", gotQ.size());
        end else begin
            nVec++;
            if (gotQ[0].val != 16239 || gotQ[0].ovf != 1'b0) begin
                nBad++;
                $display("[TB] FAIL vector_value got %0d/%0b want 16239/0", gotQ[0].val, gotQ[0].ovf);
            end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    task automatic test_back_to_back();
        bit ok, a;
        int budget;
        set_target(0);
        outReady = 1'b0;
        send(8'sd1, 8'sd1, 1'b1);
        send(8'sd2, 8'sd2, 1'b1);
        budget = 0;
        while (obsOutValid !== 1'b1 && budget < 20) begin
            step(a);
            budget++;
        end
        op1 = 8'sd3;
        op2 = 8'sd3;
        inLast = 1'b1;
        inValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(a);
            nVec++;
            if (a || obsInReady !== 1'b0 || obsOutValid !== 1'b1 || obsAcc !== 32'sd1) begin
                nBad++;
                $display("[TB] FAIL hold_cycle%0d got acc=%b rdy=%b vld=%b out=%0d want 0 0 1 1",
                         i, a, obsInReady, obsOutValid, obsAcc);
            end
        end
        inValid = 1'b0;
        outReady = 1'b1;
        send(8'sd3, 8'sd3, 1'b1);
        drain(ok);
        nVec++;
        if (gotQ.size() != 3) begin
            nBad++;
            $display("[TB] FAIL hold_count got %0d want 3", gotQ.size());
        end else begin
            nVec++;
            if (gotQ[0].val != 1 || gotQ[1].val != 4 || gotQ[2].val != 9) begin
                nBad++;
                $display("[TB] FAIL hold_values got %0d,%0d,%0d want 1,4,9",
                         gotQ[0].val, gotQ[1].val, gotQ[2].val);
            end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    task automatic test_overflow();
        bit ok;
        longint wantVal;
        for (int s = 1; s <= 2; s++) begin
            set_target(s);
            send(-8'sd128, -8'sd128, 1'b0);
            send(-8'sd128, -8'sd128, 1'b0);
            send(-8'sd128, -8'sd128, 1'b1);
            send(8'sd1, 8'sd1, 1'b1);
            drain(ok);
            wantVal = (s == 1) ? 32767 : -16384;
            nVec++;
            if (gotQ.size() != 2) begin
                nBad++;
                $display("[TB] FAIL ovf_count_sat%0d got %0d want 2", s == 1, gotQ.size());
            end else begin
                nVec++;
                if (gotQ[0].val != wantVal || gotQ[0].ovf != 1'b1) begin
                    nBad++;
                    $display("[TB] FAIL ovf_value_sat%0d got %0d/%0b want %0d/1",
                             s == 1, gotQ[0].val, gotQ[0].ovf, wantVal);
                end
                nVec++;
                if (gotQ[1].val != 1 || gotQ[1].ovf != 1'b0) begin
                    nBad++;
                    $display("[TB] FAIL ovf_next_sat%0d got %0d/%0b want 1/0",
                             s == 1, gotQ[1].val, gotQ[1].ovf);
                end
            end
            expQ.delete();
            gotQ.delete();
        end
    endtask

    task automatic test_reset_midvector();
        bit ok;
        set_target(0);
        send(8'sd10, 8'sd10, 1'b0);
        send(8'sd10, 8'sd10, 1'b0);
        do_reset();
        send(8'sd2, 8'sd3, 1'b1);
        drain(ok);
        nVec++;
        if (gotQ.size() != 1) begin
            nBad++;
            $display("[TB] FAIL midreset_count got %0d want 1", gotQ.size());
        end else begin
            nVec++;
            if (gotQ[0].val != 6 || gotQ[0].ovf != 1'b0) begin
                nBad++;
                $display("[TB] FAIL midreset_value got %0d/%0b want 6/0", gotQ[0].val, gotQ[0].ovf);
            end
        end
        expQ.delete();
        gotQ.delete();
    endtask

    task automatic test_random();
        bit ok, a;
        int len, n;
        logic signed [7:0] ra, rb;
        for (int s = 0; s < 3; s++) begin
            set_target(s);
            rndReady = 1'b1;
            for (int v = 0; v < 700; v++) begin
                len = $urandom_range(1, 16);
                for (int b = 0; b < len; b++) begin
                    while (($urandom % 4) == 0) begin
                        inValid = 1'b0;
                        outReady = ($urandom % 4) != 0;
                        step(a);
                    end
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    if (($urandom % 4) == 0) ra = ($urandom % 2) ? -8'sd128 : 8'sd127;
                    if (($urandom % 4) == 0) rb = ($urandom % 2) ? -8'sd128 : 8'sd127;
                    send(ra, rb, b == len - 1);
                end
            end
            rndReady = 1'b0;
            drain(ok);
            nVec++;
            if (!ok) begin
                nBad++;
                $display("[TB] FAIL random_count_dut%0d got %0d want %0d", s, gotQ.size(), expQ.size());
            end
            n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
            for (int i = 0; i < n; i++) begin
                nVec++;
                if (gotQ[i].val != expQ[i].val || gotQ[i].ovf != expQ[i].ovf) begin
                    nBad++;
                    $display("[TB] FAIL random_dut%0d_vec%0d got %0d/%0b want %0d/%0b",
                             s, i, gotQ[i].val, gotQ[i].ovf, expQ[i].val, expQ[i].ovf);
                end
            end
            expQ.delete();
            gotQ.delete();
        end
    endtask

    initial begin
        #950000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_vector();
        test_back_to_back();
        test_overflow();
        test_reset_midvector();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
